// File: rtl/m_unit_arbiter_pkg.sv
// Shared definitions for the M-unit arbiter: FSM state type, defaults and
// the RV32M instruction decode helpers.
package m_unit_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int ARB_TIMEOUT = 64;

  localparam logic [6:0] OPCODE = 7'b0110011;
  localparam logic [6:0] FUNC7  = 7'b0000001;

  function automatic logic [6:0] get_ir_opcode(input logic [31:0] ir);
    return ir[6:0];
  endfunction

  function automatic logic [6:0] get_ir_func7(input logic [31:0] ir);
    return ir[31:25];
  endfunction

  function automatic logic is_m_insn(input logic [31:0] ir);
    return (get_ir_opcode(ir) == OPCODE) && (get_ir_func7(ir) == FUNC7);
  endfunction

endpackage

// File: rtl/m_unit_arbiter_if.sv
// Requester-side PCPI bundle (vectored per requester) and the single PCPI
// link to the shared M unit.
interface m_unit_arbiter_req_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0][31:0] req_insn;
  logic [NUM_REQ-1:0][31:0] req_rs1;
  logic [NUM_REQ-1:0][31:0] req_rs2;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_wr;
  logic [31:0]              req_rd;
  logic [NUM_REQ-1:0]       req_busy;

  modport master (
    output req_valid, req_insn, req_rs1, req_rs2,
    input  req_ready, req_wr, req_rd, req_busy
  );

  modport slave (
    input  req_valid, req_insn, req_rs1, req_rs2,
    output req_ready, req_wr, req_rd, req_busy
  );
endinterface

interface m_unit_arbiter_pcpi_if;
  logic        m_valid;
  logic [31:0] m_insn;
  logic [31:0] m_rs1;
  logic [31:0] m_rs2;
  logic        m_ready;
  logic        m_wr;
  logic [31:0] m_rd;
  logic        m_busy;

  modport master (
    output m_valid, m_insn, m_rs1, m_rs2,
    input  m_ready, m_wr, m_rd, m_busy
  );

  modport slave (
    input  m_valid, m_insn, m_rs1, m_rs2,
    output m_ready, m_wr, m_rd, m_busy
  );
endinterface

// File: rtl/m_unit_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search starts one past last_grant and
// wraps, returning both a one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int               idx;
  logic [IDX_W-1:0] idx_sel;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    idx_sel   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx     = (int'(last_grant) + off) % NUM_REQ;
      idx_sel = IDX_W'(idx);
      if (!found && req[idx_sel]) begin
        found          = 1'b1;
        grant[idx_sel] = 1'b1;
        grant_idx      = idx_sel;
      end
    end
  end

endmodule

// File: rtl/m_unit_arbiter.sv
// Shares one PCPI M-extension unit among NUM_REQ requesters, one
// instruction at a time, with round-robin fairness and a hang timeout.
module m_unit_arbiter
  import m_unit_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         resetn,
  m_unit_arbiter_req_if.slave          req_if,
  m_unit_arbiter_pcpi_if.master        m_if,
  output logic                         timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [31:0]      insn_q, insn_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic [31:0]      rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_REQ-1:0]       elig;
  logic [NUM_REQ-1:0]       rr_grant;
  logic [IDX_W-1:0]         rr_idx;
  logic [NUM_REQ-1:0][31:0] insn_and, rs1_and, rs2_and;
  logic [31:0]              sel_insn, sel_rs1, sel_rs2;

  // The M unit's own busy flag carries no information we act on.
  logic unused_m_busy;
  assign unused_m_busy = m_if.m_busy;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign elig[gi]     = req_if.req_valid[gi] && is_m_insn(req_if.req_insn[gi]) && !mask_q[gi];
    assign insn_and[gi] = req_if.req_insn[gi] & {32{rr_grant[gi]}};
    assign rs1_and[gi]  = req_if.req_rs1[gi]  & {32{rr_grant[gi]}};
    assign rs2_and[gi]  = req_if.req_rs2[gi]  & {32{rr_grant[gi]}};

    assign req_if.req_ready[gi] = (state_q == RESP) && (grant_q == IDX_W'(gi));
    assign req_if.req_wr[gi]    = (state_q == RESP) && (grant_q == IDX_W'(gi)) && wr_q;
    assign req_if.req_busy[gi]  = ((state_q == ISSUE) || (state_q == WAIT)) && (grant_q == IDX_W'(gi));
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req        (elig),
    .last_grant (last_q),
    .grant      (rr_grant),
    .grant_idx  (rr_idx)
  );

  // One-hot AND-OR select of the winning requester's operands.
  always_comb begin
    sel_insn = '0;
    sel_rs1  = '0;
    sel_rs2  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_insn = sel_insn | insn_and[i];
      sel_rs1  = sel_rs1  | rs1_and[i];
      sel_rs2  = sel_rs2  | rs2_and[i];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    mask_d  = '0;
    insn_d  = insn_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          grant_d = rr_idx;
          insn_d  = sel_insn;
          rs1_d   = sel_rs1;
          rs2_d   = sel_rs2;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (m_if.m_ready) begin
          rd_d    = m_if.m_rd;
          wr_d    = m_if.m_wr;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          // Abandon the hung op; the owner still gets a no-write completion.
          rd_d    = '0;
          wr_d    = 1'b0;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        last_d          = grant_q;
        mask_d[grant_q] = 1'b1;
        to_d            = 1'b0;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      mask_q  <= '0;
      insn_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
      insn_q  <= insn_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  // Holding registers feed the M unit directly so operands stay put for
  // its completion-time sign fix-up.
  assign m_if.m_valid  = (state_q == ISSUE);
  assign m_if.m_insn   = insn_q;
  assign m_if.m_rs1    = rs1_q;
  assign m_if.m_rs2    = rs2_q;
  assign req_if.req_rd = (state_q == RESP) ? rd_q : '0;
  assign timeout_err   = (state_q == RESP) && to_q;

endmodule

// File: tb/tb_m_unit_arbiter.sv
// Directed bench for m_unit_arbiter: a stub M unit answers ops, a scoreboard
// queue holds expected completions and a negedge monitor checks them.
`timescale 1ns/1ps
module tb_m_unit_arbiter;

  localparam int N = 2;
  localparam logic [31:0] I_MUL   = 32'h02B50533;
  localparam logic [31:0] I_DIV   = 32'h02B54533;
  localparam logic [31:0] I_MULHU = 32'h02B53533;
  localparam logic [31:0] I_ADD   = 32'h00B50533;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic timeout_err;

  always #5 clk = ~clk;

  m_unit_arbiter_req_if #(.NUM_REQ(N)) req_bus ();
  m_unit_arbiter_pcpi_if m_bus ();

  m_unit_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (64)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_if      (req_bus),
    .m_if        (m_bus),
    .timeout_err (timeout_err)
  );

  typedef struct {
    int          idx;
    logic        wr;
    logic [31:0] rd;
    logic        to;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   mv_cnt   = 0;
  int   busy_cnt = 0;
  int   viol     = 0;
  bit   track_div = 1'b0;
  bit   stub_hang = 1'b0;
  bit   stub_busy;
  int   stub_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  function automatic logic [31:0] m_result(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [2:0]  f3;
    f3 = insn[14:12];
    p  = {32'b0, a} * {32'b0, b};
    case (f3)
      3'd0:    return p[31:0];
      3'd3:    return p[63:32];
      3'd4:    return (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
      default: return 32'h0;
    endcase
  endfunction

  // Stub M unit: MUL ready 4 cycles after pcpi_valid, DIV 36; reads operands at completion.
  always @(posedge clk or posedge resetn) begin
    if (resetn) begin
      stub_busy     <= 1'b0;
      stub_cnt      <= 0;
      m_bus.m_ready <= 1'b0;
      m_bus.m_wr    <= 1'b0;
      m_bus.m_rd    <= '0;
    end else begin
      m_bus.m_ready <= 1'b0;
      m_bus.m_wr    <= 1'b0;
      if (m_bus.m_valid && !stub_busy && !stub_hang) begin
        stub_busy <= 1'b1;
        stub_cnt  <= m_bus.m_insn[14] ? 34 : 2;
      end else if (stub_busy) begin
        if (stub_cnt == 0) begin
          m_bus.m_ready <= 1'b1;
          m_bus.m_wr    <= 1'b1;
          m_bus.m_rd    <= m_result(m_bus.m_insn, m_bus.m_rs1, m_bus.m_rs2);
          stub_busy     <= 1'b0;
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end
  assign m_bus.m_busy = stub_busy;

  // Monitor: pops the scoreboard whenever a completion is presented.
  always @(negedge clk) begin
    if (!resetn) begin
      if (m_bus.m_valid) mv_cnt++;
      if (track_div && req_bus.req_busy[0]) begin
        busy_cnt++;
        if (m_bus.m_rs1 !== 32'd100 || m_bus.m_insn !== I_DIV) viol++;
      end
      if (req_bus.req_ready != '0 || timeout_err) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: ready=%b to=%b rd=%h at cycle %0d, required no response",
                   req_bus.req_ready, timeout_err, req_bus.req_rd, cyc);
        end else begin
          e = sb.pop_front();
          $display("resp: req%0d rd=%h wr=%b to=%b cycle=%0d", e.idx, req_bus.req_rd,
                   req_bus.req_wr, timeout_err, cyc);
          check("resp_ready", 32'(req_bus.req_ready), 32'(1 << e.idx));
          check("resp_wr", 32'(req_bus.req_wr), e.wr ? 32'(1 << e.idx) : 32'd0);
          check("resp_rd", req_bus.req_rd, e.rd);
          check("resp_timeout_err", 32'(timeout_err), 32'(e.to));
          check("resp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        check("rd_idle_zero", req_bus.req_rd, 32'd0);
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] insn,
                         input logic [31:0] a, input logic [31:0] b);
    req_bus.req_valid[i] = v;
    req_bus.req_insn[i]  = insn;
    req_bus.req_rs1[i]   = a;
    req_bus.req_rs2[i]   = b;
  endtask

  task automatic push(input int idx, input logic wr, input logic [31:0] rd,
                      input logic to, input int at);
    exp_t x;
    x.idx = idx; x.wr = wr; x.rd = rd; x.to = to; x.cyc = at;
    sb.push_back(x);
  endtask

  task automatic pulse_reset();
    resetn = 1'b1;
    wait_cyc(cyc + 1);
    resetn = 1'b0;
    wait_cyc(cyc + 1);
  endtask

  initial begin
    int t0, t1, mv0;
    req_bus.req_valid = '0;
    req_bus.req_insn  = '0;
    req_bus.req_rs1   = '0;
    req_bus.req_rs2   = '0;
    resetn = 1'b1;
    wait_cyc(3);

    check("rst_m_valid", 32'(m_bus.m_valid), 32'd0);
    check("rst_req_ready", 32'(req_bus.req_ready), 32'd0);
    check("rst_req_wr", 32'(req_bus.req_wr), 32'd0);
    check("rst_req_busy", 32'(req_bus.req_busy), 32'd0);
    check("rst_req_rd", req_bus.req_rd, 32'd0);
    check("rst_m_insn", m_bus.m_insn, 32'd0);
    check("rst_m_rs1", m_bus.m_rs1, 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    resetn = 1'b0;
    wait_cyc(cyc + 2);

    // Single MUL; valid lags one cycle past RESP to exercise the mask.
    t0 = cyc; mv0 = mv_cnt;
    set_req(0, 1'b1, I_MUL, 32'd7, 32'd6);
    push(0, 1'b1, 32'd42, 1'b0, t0 + 6);
    wait_cyc(t0 + 8);
    req_bus.req_valid[0] = 1'b0;
    wait_cyc(t0 + 12);
    check("mul_m_valid_cycles", 32'(mv_cnt - mv0), 32'd1);
    check("mul_sb_empty", 32'(sb.size()), 32'd0);

    // Contention from reset: DIV on req0 wins, MUL on req1 follows.
    pulse_reset();
    t0 = cyc; mv0 = mv_cnt; busy_cnt = 0; viol = 0; track_div = 1'b1;
    set_req(0, 1'b1, I_DIV, 32'd100, 32'd7);
    set_req(1, 1'b1, I_MUL, 32'd3, 32'd5);
    push(0, 1'b1, 32'd14, 1'b0, t0 + 38);
    push(1, 1'b1, 32'd15, 1'b0, t0 + 45);
    wait_cyc(t0 + 40);
    req_bus.req_valid[0] = 1'b0;
    wait_cyc(t0 + 47);
    req_bus.req_valid[1] = 1'b0;
    track_div = 1'b0;
    check("div_busy_cycles", 32'(busy_cnt), 32'd37);
    check("div_operand_stable_violations", 32'(viol), 32'd0);
    check("cont_m_valid_cycles", 32'(mv_cnt - mv0), 32'd2);
    check("cont_sb_empty", 32'(sb.size()), 32'd0);

    // Fairness: both always valid, grants alternate starting at 0.
    t0 = cyc; mv0 = mv_cnt;
    set_req(0, 1'b1, I_MUL, 32'd2, 32'd3);
    set_req(1, 1'b1, I_MUL, 32'd4, 32'd5);
    for (int k = 0; k < 6; k++)
      push(k % 2, 1'b1, (k % 2 == 1) ? 32'd20 : 32'd6, 1'b0, t0 + 6 + 7 * k);
    wait_cyc(t0 + 41);
    req_bus.req_valid = '0;
    wait_cyc(t0 + 45);
    check("fair_m_valid_cycles", 32'(mv_cnt - mv0), 32'd6);
    check("fair_sb_empty", 32'(sb.size()), 32'd0);

    // Non-M instruction is never issued; an M request alongside still is.
    t0 = cyc; mv0 = mv_cnt;
    set_req(1, 1'b1, I_ADD, 32'd1, 32'd2);
    wait_cyc(t0 + 20);
    check("nonm_m_valid_cycles", 32'(mv_cnt - mv0), 32'd0);
    check("nonm_req_busy", 32'(req_bus.req_busy), 32'd0);
    t1 = cyc;
    set_req(0, 1'b1, I_MULHU, 32'h8000_0000, 32'd4);
    push(0, 1'b1, 32'd2, 1'b0, t1 + 6);
    wait_cyc(t1 + 8);
    req_bus.req_valid = '0;
    wait_cyc(t1 + 12);
    check("mulhu_m_valid_cycles", 32'(mv_cnt - mv0), 32'd1);
    check("mulhu_sb_empty", 32'(sb.size()), 32'd0);

    // Hung M unit: abort 65 cycles after ISSUE with wr=0.
    stub_hang = 1'b1;
    t0 = cyc; mv0 = mv_cnt;
    set_req(1, 1'b1, I_MUL, 32'd3, 32'd3);
    push(1, 1'b0, 32'd0, 1'b1, t0 + 66);
    wait_cyc(t0 + 68);
    req_bus.req_valid = '0;
    wait_cyc(t0 + 72);
    stub_hang = 1'b0;
    check("to_m_valid_cycles", 32'(mv_cnt - mv0), 32'd1);
    check("to_sb_empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of a DIV, then a contended restart.
    t0 = cyc;
    set_req(0, 1'b1, I_DIV, 32'd100, 32'd7);
    wait_cyc(t0 + 10);
    check("rdiv_req_busy", 32'(req_bus.req_busy), 32'd1);
    wait_cyc(t0 + 20);
    resetn = 1'b1;
    req_bus.req_valid = '0;
    @(negedge clk);
    check("rdiv_m_valid", 32'(m_bus.m_valid), 32'd0);
    check("rdiv_req_busy_clr", 32'(req_bus.req_busy), 32'd0);
    check("rdiv_req_ready", 32'(req_bus.req_ready), 32'd0);
    check("rdiv_m_insn", m_bus.m_insn, 32'd0);
    check("rdiv_m_rs1", m_bus.m_rs1, 32'd0);
    check("rdiv_m_rs2", m_bus.m_rs2, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    wait_cyc(cyc + 2);
    t1 = cyc; mv0 = mv_cnt;
    set_req(0, 1'b1, I_MUL, 32'd7, 32'd6);
    set_req(1, 1'b1, I_MUL, 32'd3, 32'd5);
    push(0, 1'b1, 32'd42, 1'b0, t1 + 6);
    push(1, 1'b1, 32'd15, 1'b0, t1 + 13);
    wait_cyc(t1 + 8);
    req_bus.req_valid[0] = 1'b0;
    wait_cyc(t1 + 15);
    req_bus.req_valid[1] = 1'b0;
    wait_cyc(t1 + 20);
    check("post_rst_m_valid_cycles", 32'(mv_cnt - mv0), 32'd2);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
